// File: rtl/victim_cache_fa.sv
// Fully-associative exclusive victim cache sitting between a direct-mapped L1 and memory.
// L1 evictions are inserted here; L1 misses probe here; dirty victims leave via a one-deep writeback buffer.
module victim_cache_fa #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int WORDS_PER_LINE = 4,
  parameter int NUM_ENTRIES    = 8,
  localparam int LINE_W        = DATA_WIDTH * WORDS_PER_LINE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  lookup_valid,
  input  logic [ADDR_WIDTH-1:0] lookup_addr,
  output logic                  lookup_hit,
  output logic                  lookup_dirty,
  output logic [LINE_W-1:0]     lookup_data,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  input  logic [ADDR_WIDTH-1:0] ins_addr,
  input  logic [LINE_W-1:0]     ins_data,
  input  logic                  ins_dirty,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [ADDR_WIDTH-1:0] wb_addr,
  output logic [LINE_W-1:0]     wb_data,
  input  logic                  flush_req,
  output logic                  flush_done
);

  localparam int OFFSET = $clog2(WORDS_PER_LINE * DATA_WIDTH / 8);
  localparam int TAG_W  = ADDR_WIDTH - OFFSET;
  localparam int AGE_W  = $clog2(NUM_ENTRIES);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(NUM_ENTRIES - 1);

  typedef enum logic [1:0] {IDLE, WB_WAIT, FLUSH_SCAN, FLUSH_WB} state_t;

  state_t                 state;
  logic [NUM_ENTRIES-1:0] valid;
  logic [NUM_ENTRIES-1:0] dirty;
  logic [TAG_W-1:0]       tag   [NUM_ENTRIES];
  logic [LINE_W-1:0]      line  [NUM_ENTRIES];
  logic [AGE_W-1:0]       age   [NUM_ENTRIES];
  logic [AGE_W-1:0]       scan_idx;
  logic [TAG_W-1:0]       wb_tag;

  logic [TAG_W-1:0] lk_tag, in_tag;
  logic             lk_hit, buf_hit, ins_present, inv_any, evict, ins_fire, scan_keep;
  logic [AGE_W-1:0] lk_idx, ins_idx, inv_idx, lru_idx, target, best_age;
  logic             unused_low_bits;

  assign lk_tag          = lookup_addr[ADDR_WIDTH-1:OFFSET];
  assign in_tag          = ins_addr[ADDR_WIDTH-1:OFFSET];
  assign unused_low_bits = ^{lookup_addr[OFFSET-1:0], ins_addr[OFFSET-1:0]};
  assign wb_addr         = ADDR_WIDTH'(wb_tag) << OFFSET;
  assign ins_ready       = rst_n && (state == IDLE) && !flush_req;
  assign ins_fire        = ins_valid && ins_ready;

  // Tag matching and victim choice; reverse scans make the lowest matching index win.
  always_comb begin
    lk_hit      = 1'b0;
    lk_idx      = '0;
    ins_present = 1'b0;
    ins_idx     = '0;
    inv_any     = 1'b0;
    inv_idx     = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (valid[i] && tag[i] == lk_tag) begin
        lk_hit = lookup_valid;
        lk_idx = AGE_W'(i);
      end
      if (valid[i] && tag[i] == in_tag) begin
        ins_present = 1'b1;
        ins_idx     = AGE_W'(i);
      end
      if (!valid[i]) begin
        inv_any = 1'b1;
        inv_idx = AGE_W'(i);
      end
    end
    lru_idx  = '0;
    best_age = age[0];
    for (int i = 1; i < NUM_ENTRIES; i++) begin
      if (age[i] > best_age) begin
        best_age = age[i];
        lru_idx  = AGE_W'(i);
      end
    end
    buf_hit   = lookup_valid && wb_valid && (wb_tag == lk_tag);
    target    = ins_present ? ins_idx : (lk_hit ? lk_idx : (inv_any ? inv_idx : lru_idx));
    evict     = !ins_present && !lk_hit && !inv_any && dirty[lru_idx];
    scan_keep = valid[scan_idx] && dirty[scan_idx] && !(lk_hit && lk_idx == scan_idx);
  end

  // Insert writes come after the lookup invalidation so a swap leaves the new line valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      valid        <= '0;
      dirty        <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) age[i] <= '0;
      scan_idx     <= '0;
      wb_valid     <= 1'b0;
      lookup_hit   <= 1'b0;
      lookup_dirty <= 1'b0;
      lookup_data  <= '0;
      flush_done   <= 1'b0;
    end else begin
      flush_done   <= 1'b0;
      lookup_hit   <= lk_hit || buf_hit;
      lookup_dirty <= lk_hit && dirty[lk_idx];
      lookup_data  <= lk_hit ? line[lk_idx] : (buf_hit ? wb_data : '0);
      if (lk_hit) valid[lk_idx] <= 1'b0;
      case (state)
        IDLE: begin
          if (ins_fire) begin
            for (int j = 0; j < NUM_ENTRIES; j++) begin
              if (AGE_W'(j) != target && valid[j] && age[j] < age[target])
                age[j] <= (age[j] == AGE_MAX) ? age[j] : age[j] + AGE_W'(1);
            end
            age[target]   <= '0;
            valid[target] <= 1'b1;
            tag[target]   <= in_tag;
            line[target]  <= ins_data;
            dirty[target] <= ins_present ? (dirty[target] | ins_dirty) : ins_dirty;
            if (evict) begin
              wb_tag   <= tag[target];
              wb_data  <= line[target];
              wb_valid <= 1'b1;
              state    <= WB_WAIT;
            end
          end else if (flush_req) begin
            scan_idx <= '0;
            state    <= FLUSH_SCAN;
          end
        end
        WB_WAIT: begin
          if (wb_ready) begin
            wb_valid <= 1'b0;
            state    <= IDLE;
          end
        end
        FLUSH_SCAN: begin
          if (scan_keep) begin
            wb_tag          <= tag[scan_idx];
            wb_data         <= line[scan_idx];
            wb_valid        <= 1'b1;
            dirty[scan_idx] <= 1'b0;
            state           <= FLUSH_WB;
          end else if (scan_idx == AGE_MAX) begin
            flush_done <= 1'b1;
            state      <= IDLE;
          end else begin
            scan_idx <= scan_idx + AGE_W'(1);
          end
        end
        FLUSH_WB: begin
          if (wb_ready) begin
            wb_valid <= 1'b0;
            if (scan_idx == AGE_MAX) begin
              flush_done <= 1'b1;
              state      <= IDLE;
            end else begin
              scan_idx <= scan_idx + AGE_W'(1);
              state    <= FLUSH_SCAN;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_victim_cache_fa.sv
// Self-checking bench for victim_cache_fa: directed scenarios then random traffic against an array-level model.
module tb_victim_cache_fa;

  localparam int N  = 4;
  localparam int LW = 128;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          lookup_valid = 1'b0;
  logic [31:0]   lookup_addr = '0;
  logic          lookup_hit, lookup_dirty;
  logic [LW-1:0] lookup_data;
  logic          ins_valid = 1'b0;
  logic          ins_ready;
  logic [31:0]   ins_addr = '0;
  logic [LW-1:0] ins_data = '0;
  logic          ins_dirty = 1'b0;
  logic          wb_valid;
  logic          wb_ready = 1'b0;
  logic [31:0]   wb_addr;
  logic [LW-1:0] wb_data;
  logic          flush_req = 1'b0;
  logic          flush_done;

  victim_cache_fa #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .WORDS_PER_LINE(4), .NUM_ENTRIES(N)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .lookup_valid(lookup_valid), .lookup_addr(lookup_addr),
    .lookup_hit(lookup_hit), .lookup_dirty(lookup_dirty), .lookup_data(lookup_data),
    .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_addr(ins_addr),
    .ins_data(ins_data), .ins_dirty(ins_dirty),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush_req(flush_req), .flush_done(flush_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: cache contents as plain arrays plus a pending-writeback slot and flush cursor.
  bit            mv[N];
  bit            md[N];
  logic [27:0]   mt[N];
  logic [LW-1:0] ml[N];
  int            ma[N];
  bit            m_wbv;
  logic [27:0]   m_wbt;
  logic [LW-1:0] m_wbd;
  bit            m_fl;
  int            m_scan;
  bit            e_hit, e_dirty, e_done;
  logic [LW-1:0] e_data;
  logic [31:0]   wb_seen[$];
  int            done_seen;

  task automatic checkOutput(input string name, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [LW-1:0] pat(input int k);
    return {4{32'hC0DE0000 + 32'(k)}};
  endfunction

  function automatic bit modelHasTag(input logic [31:0] a);
    for (int i = 0; i < N; i++) if (mv[i] && mt[i] == a[31:4]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < N; i++) begin
      mv[i] = 0; md[i] = 0; ma[i] = 0; mt[i] = '0; ml[i] = '0;
    end
    m_wbv = 0; m_fl = 0; m_scan = 0;
    e_hit = 0; e_dirty = 0; e_done = 0; e_data = '0;
  endtask

  task automatic modelStep(input bit lv, input logic [31:0] la, input bit iv, input logic [31:0] ia,
                           input logic [LW-1:0] idat, input bit idr, input bit wr, input bit fr);
    bit nv[N], nd[N];
    logic [27:0] nt[N];
    logic [LW-1:0] nl[N];
    int na[N];
    bit nwbv, nfl, idle, ev;
    logic [27:0] nwbt;
    logic [LW-1:0] nwbd;
    int nscan, e, p, t;
    nv = mv; nd = md; nt = mt; nl = ml; na = ma;
    nwbv = m_wbv; nwbt = m_wbt; nwbd = m_wbd; nfl = m_fl; nscan = m_scan;
    idle = !m_wbv && !m_fl;
    e = -1; p = -1;
    for (int i = 0; i < N; i++) begin
      if (mv[i] && mt[i] == la[31:4] && e < 0) e = i;
      if (mv[i] && mt[i] == ia[31:4] && p < 0) p = i;
    end
    if (!lv) e = -1;
    e_hit = 0; e_dirty = 0; e_data = '0; e_done = 0;
    if (e >= 0) begin
      e_hit = 1; e_dirty = md[e]; e_data = ml[e]; nv[e] = 0;
    end else if (lv && m_wbv && m_wbt == la[31:4]) begin
      e_hit = 1; e_data = m_wbd;
    end
    if (iv && idle && !fr) begin
      ev = 0;
      if (p >= 0) begin
        t = p; nd[t] = md[p] | idr;
      end else begin
        if (e >= 0) t = e;
        else begin
          t = -1;
          for (int i = 0; i < N; i++) if (!mv[i] && t < 0) t = i;
          if (t < 0) begin
            t = 0;
            for (int i = 1; i < N; i++) if (ma[i] > ma[t]) t = i;
            ev = md[t];
          end
        end
        nd[t] = idr;
      end
      if (ev) begin
        nwbv = 1; nwbt = mt[t]; nwbd = ml[t];
      end
      for (int j = 0; j < N; j++)
        if (j != t && mv[j] && ma[j] < ma[t]) na[j] = (ma[j] + 1 > N - 1) ? N - 1 : ma[j] + 1;
      na[t] = 0; nv[t] = 1; nt[t] = ia[31:4]; nl[t] = idat;
    end
    if (m_fl && !m_wbv) begin
      if (e != m_scan && mv[m_scan] && md[m_scan]) begin
        nwbv = 1; nwbt = mt[m_scan]; nwbd = ml[m_scan]; nd[m_scan] = 0;
      end else if (m_scan == N - 1) begin
        e_done = 1; nfl = 0;
      end else nscan = m_scan + 1;
    end
    if (m_wbv && wr) begin
      nwbv = 0;
      if (m_fl) begin
        if (m_scan == N - 1) begin e_done = 1; nfl = 0; end
        else nscan = m_scan + 1;
      end
    end
    if (idle && fr) begin nfl = 1; nscan = 0; end
    mv = nv; md = nd; mt = nt; ml = nl; ma = na;
    m_wbv = nwbv; m_wbt = nwbt; m_wbd = nwbd; m_fl = nfl; m_scan = nscan;
  endtask

  task automatic applyStimulus(input bit lv, input logic [31:0] la, input bit iv, input logic [31:0] ia,
                               input logic [LW-1:0] idat, input bit idr, input bit wr, input bit fr);
    @(negedge clk);
    lookup_valid = lv; lookup_addr = la;
    ins_valid = iv; ins_addr = ia; ins_data = idat; ins_dirty = idr;
    wb_ready = wr; flush_req = fr;
    #1;
    checkOutput("ins_ready", LW'(ins_ready), LW'(!m_wbv && !m_fl && !fr));
    if (wb_valid && wr) wb_seen.push_back(wb_addr);
    modelStep(lv, la, iv, ia, idat, idr, wr, fr);
    @(posedge clk);
    #1;
    checkOutput("lookup_hit", LW'(lookup_hit), LW'(e_hit));
    checkOutput("lookup_dirty", LW'(lookup_dirty), LW'(e_dirty));
    checkOutput("lookup_data", lookup_data, e_data);
    checkOutput("wb_valid", LW'(wb_valid), LW'(m_wbv));
    if (m_wbv) begin
      checkOutput("wb_addr", LW'(wb_addr), LW'({m_wbt, 4'h0}));
      checkOutput("wb_data", wb_data, m_wbd);
    end
    checkOutput("flush_done", LW'(flush_done), LW'(e_done));
    if (flush_done) done_seen++;
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst_n = 0; lookup_valid = 0; ins_valid = 0; wb_ready = 0; flush_req = 0;
    #1;
    checkOutput("rst_ins_ready", LW'(ins_ready), LW'(0));
    @(posedge clk);
    #1;
    modelReset();
    checkOutput("rst_lookup_hit", LW'(lookup_hit), LW'(0));
    checkOutput("rst_lookup_data", lookup_data, LW'(0));
    checkOutput("rst_wb_valid", LW'(wb_valid), LW'(0));
    checkOutput("rst_flush_done", LW'(flush_done), LW'(0));
    rst_n = 1;
  endtask

  task automatic ins(input logic [31:0] a, input logic [LW-1:0] d, input bit dr, input bit wr);
    applyStimulus(0, '0, 1, a, d, dr, wr, 0);
  endtask

  task automatic look(input logic [31:0] a);
    applyStimulus(1, a, 0, '0, '0, 0, 1, 0);
  endtask

  task automatic fillFour(input bit firstDirty);
    ins(32'h000, pat(0), firstDirty, 1);
    ins(32'h010, pat(1), 0, 1);
    ins(32'h020, pat(2), 0, 1);
    ins(32'h030, pat(3), 0, 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    bit lv, iv, dr, wr, fr;
    logic [31:0] la, ia;

    resetDut();
    ins(32'h100, {4{32'hAAAAAAAA}}, 0, 1);
    look(32'h104);
    checkOutput("t1_hit", LW'(lookup_hit), LW'(1));
    checkOutput("t1_data", lookup_data, {4{32'hAAAAAAAA}});
    look(32'h104);
    checkOutput("t1_rehit", LW'(lookup_hit), LW'(0));
    checkOutput("t1_redata", lookup_data, LW'(0));

    resetDut();
    fillFour(0);
    ins(32'h040, pat(4), 0, 1);
    checkOutput("t2_wbv", LW'(wb_valid), LW'(0));
    look(32'h000);
    checkOutput("t2_miss", LW'(lookup_hit), LW'(0));

    resetDut();
    fillFour(1);
    ins(32'h040, pat(4), 0, 0);
    checkOutput("t3_wbv", LW'(wb_valid), LW'(1));
    checkOutput("t3_wbaddr", LW'(wb_addr), LW'(32'h000));
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, '0, 0, '0, '0, 0, 0, 0);
      checkOutput("t3_stall_wbaddr", LW'(wb_addr), LW'(32'h000));
      checkOutput("t3_stall_rdy", LW'(ins_ready), LW'(0));
    end
    applyStimulus(0, '0, 0, '0, '0, 0, 1, 0);
    checkOutput("t3_done_wbv", LW'(wb_valid), LW'(0));
    checkOutput("t3_done_rdy", LW'(ins_ready), LW'(1));

    resetDut();
    fillFour(0);
    applyStimulus(1, 32'h020, 1, 32'h050, pat(5), 0, 1, 0);
    checkOutput("t4_hit", LW'(lookup_hit), LW'(1));
    checkOutput("t4_data", lookup_data, pat(2));
    checkOutput("t4_wbv", LW'(wb_valid), LW'(0));
    look(32'h050);
    checkOutput("t4_newline", lookup_data, pat(5));
    look(32'h000);
    checkOutput("t4_kept", LW'(lookup_hit), LW'(1));

    resetDut();
    ins(32'h000, pat(0), 1, 1);
    ins(32'h010, pat(1), 0, 1);
    ins(32'h020, pat(2), 1, 1);
    ins(32'h030, pat(3), 0, 1);
    wb_seen.delete();
    done_seen = 0;
    applyStimulus(0, '0, 0, '0, '0, 0, 1, 1);
    for (int i = 0; i < 12; i++) applyStimulus(0, '0, 0, '0, '0, 0, 1, 0);
    checkOutput("t5_wbcount", LW'(wb_seen.size()), LW'(2));
    checkOutput("t5_wb0", LW'(wb_seen.size() > 0 ? wb_seen[0] : 32'hFFFFFFFF), LW'(32'h000));
    checkOutput("t5_wb1", LW'(wb_seen.size() > 1 ? wb_seen[1] : 32'hFFFFFFFF), LW'(32'h020));
    checkOutput("t5_donecount", LW'(done_seen), LW'(1));
    look(32'h000);
    checkOutput("t5_hit", LW'(lookup_hit), LW'(1));
    checkOutput("t5_clean", LW'(lookup_dirty), LW'(0));

    resetDut();
    fillFour(1);
    ins(32'h040, pat(4), 0, 0);
    checkOutput("t6_pre_wbv", LW'(wb_valid), LW'(1));
    resetDut();
    checkOutput("t6_wbv", LW'(wb_valid), LW'(0));
    look(32'h000);
    checkOutput("t6_rdy", LW'(ins_ready), LW'(1));
    checkOutput("t6_miss0", LW'(lookup_hit), LW'(0));
    look(32'h040);
    checkOutput("t6_miss40", LW'(lookup_hit), LW'(0));

    resetDut();
    for (int c = 0; c < 1500; c++) begin
      lv = 1'($urandom_range(0, 1));
      la = ($urandom_range(0, 7) << 4) | $urandom_range(0, 15);
      iv = ($urandom_range(0, 9) < 4);
      ia = ($urandom_range(0, 7) << 4) | $urandom_range(0, 15);
      dr = 1'($urandom_range(0, 1));
      wr = ($urandom_range(0, 9) < 7);
      fr = ($urandom_range(0, 29) == 0);
      if (lv && iv && !m_wbv && !m_fl && !fr && modelHasTag(la) && modelHasTag(ia)) lv = 0;
      applyStimulus(lv, la, iv, ia, {$urandom, $urandom, $urandom, $urandom}, dr, wr, fr);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
